// File: rtl/jk_bank_ctrl_if.sv
// Command and bank bus between a host, the jk_bank_ctrl sequencer and
// the bank of JK flip-flops it drives.
//
// Handshake: the host raises start for one cycle while busy is low and
// done is low. The sequencer samples start, mode, load_val and steps
// only in IDLE. It raises busy while the command executes. It pulses
// done for one cycle at completion. A start that arrives while busy or
// done is high is dropped. abort is honoured only while a count command
// is running.
interface jk_bank_ctrl_if #(
   parameter int WIDTH  = 4,
   parameter int STEP_W = 8
) ();
   logic              start;
   logic [1:0]        mode;
   logic [WIDTH-1:0]  load_val;
   logic [STEP_W-1:0] steps;
   logic              abort;
   logic [WIDTH-1:0]  q_fb;
   logic [WIDTH-1:0]  j;
   logic [WIDTH-1:0]  k;
   logic              ff_rst;
   logic              busy;
   logic              done;
   logic              tc;
   logic [2:0]        dbg_state;

   // Host side: issues commands, returns bank Q
   modport master (
      output start, mode, load_val, steps, abort, q_fb,
      input  j, k, ff_rst, busy, done, tc, dbg_state
   );

   // Sequencer side
   modport slave (
      input  start, mode, load_val, steps, abort, q_fb,
      output j, k, ff_rst, busy, done, tc, dbg_state
   );
endinterface

// File: rtl/jk_bank_ctrl.sv
// Sequencer for a bank of JK flops that form a wrap-around counter
// covering 0..MAX_CNT. It computes per-bit J/K drive from fed-back Q.
// It supports up/down counting for N steps, saturating load and clear.
module jk_bank_ctrl #(
   parameter int WIDTH   = 4,
   parameter int MAX_CNT = 9,
   parameter int STEP_W  = 8
) (
   input logic         clk,
   input logic         rst_n,
   jk_bank_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RUN  = 3'd1,
      S_LOAD = 3'd2,
      S_CLR  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_CNT);

   state_t            state_q, state_d;
   logic              dir_q, dir_d;          // 1 = count down
   logic [WIDTH-1:0]  load_val_q, load_val_d;
   logic [STEP_W-1:0] rem_q, rem_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              tc_q, tc_d;
   logic              ff_rst_q, ff_rst_d;

   logic [WIDTH-1:0]  tmask;
   logic [WIDTH-1:0]  j_c, k_c;
   logic [WIDTH-1:0]  load_sat;
   logic              wrap;

   // A genuine wrap: terminal value reached in the counting direction.
   // Out-of-range recovery does not count as a wrap.
   assign wrap = dir_q ? (bus.q_fb == '0) : (bus.q_fb == MAX_V);

   // Per-bit J/K drive from state, captured command and bank Q
   always_comb begin
      j_c      = '0;
      k_c      = '0;
      tmask    = '0;
      load_sat = (load_val_q > MAX_V) ? MAX_V : load_val_q;
      case (state_q)
         S_RUN: begin
            if (!bus.abort) begin
               if (!dir_q) begin
                  if (bus.q_fb >= MAX_V) begin
                     k_c = '1;
                  end else begin
                     tmask[0] = 1'b1;
                     for (int i = 1; i < WIDTH; i++)
                        tmask[i] = tmask[i-1] & bus.q_fb[i-1];
                     j_c = tmask;
                     k_c = tmask;
                  end
               end else begin
                  if (bus.q_fb == '0 || bus.q_fb > MAX_V) begin
                     j_c = MAX_V;
                     k_c = ~MAX_V;
                  end else begin
                     tmask[0] = 1'b1;
                     for (int i = 1; i < WIDTH; i++)
                        tmask[i] = tmask[i-1] & ~bus.q_fb[i-1];
                     j_c = tmask;
                     k_c = tmask;
                  end
               end
            end
         end
         S_LOAD: begin
            j_c = load_sat;
            k_c = ~load_sat;
         end
         default: ;
      endcase
   end

   // Next state, command capture and registered status outputs
   always_comb begin
      state_d    = state_q;
      dir_d      = dir_q;
      load_val_d = load_val_q;
      rem_d      = rem_q;
      tc_d       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               dir_d      = bus.mode[0];
               load_val_d = bus.load_val;
               rem_d      = bus.steps;
               case (bus.mode)
                  2'b00, 2'b01: state_d = (bus.steps == '0) ? S_DONE : S_RUN;
                  2'b10:        state_d = S_LOAD;
                  default:      state_d = S_CLR;
               endcase
            end
         end
         S_RUN: begin
            if (bus.abort) begin
               state_d = S_DONE;
            end else begin
               rem_d = rem_q - STEP_W'(1);
               tc_d  = wrap;
               if (rem_q == STEP_W'(1))
                  state_d = S_DONE;
            end
         end
         S_LOAD:  state_d = S_DONE;
         S_CLR:   state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d   = (state_d == S_RUN) || (state_d == S_LOAD) || (state_d == S_CLR);
      done_d   = (state_d == S_DONE);
      ff_rst_d = (state_d == S_CLR);
   end

   // State and output registers; the bank is held in reset while rst_n is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         dir_q      <= 1'b0;
         load_val_q <= '0;
         rem_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         tc_q       <= 1'b0;
         ff_rst_q   <= 1'b1;
      end else begin
         state_q    <= state_d;
         dir_q      <= dir_d;
         load_val_q <= load_val_d;
         rem_q      <= rem_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         tc_q       <= tc_d;
         ff_rst_q   <= ff_rst_d;
      end
   end

   assign bus.j         = j_c;
   assign bus.k         = k_c;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.tc        = tc_q;
   assign bus.ff_rst    = ff_rst_q;
   assign bus.dbg_state = state_q;

endmodule
